// File: rtl/xpb_pkg.sv
// xpb_pkg: shared widths, sum-width helper and FSM state type for the xpb reduction path.
package xpb_pkg;
  localparam int XPB_WORD_W = 1024;
  localparam int XPB_IDX_W = 5;
  typedef enum logic [1:0] {IDLE, LOOKUP, ACCUM, DONE} state_e;
  function automatic int sum_w(input int word_w, input int num_terms);
    return word_w + $clog2(num_terms + 1);
  endfunction
endpackage

// File: rtl/xpb_term_adder.sv
// xpb_term_adder: acc + T table terms via a 3:2 carry-save chain and one final carry-propagate add.
module xpb_term_adder import xpb_pkg::*; #(
  parameter int WORD_W = XPB_WORD_W,
  parameter int T = 2,
  parameter int SUM_W = sum_w(XPB_WORD_W, 8)
) (
  input  logic [SUM_W-1:0]    acc_i,
  input  logic [T*WORD_W-1:0] terms_i,
  output logic [SUM_W-1:0]    sum_o
);
  logic [SUM_W-1:0] s, c, t, cn;
  always_comb begin
    s = acc_i;
    c = '0;
    t = '0;
    cn = '0;
    for (int i = 0; i < T; i++) begin
      t = SUM_W'(terms_i[i*WORD_W +: WORD_W]);
      cn = ((s & c) | (s & t) | (c & t)) << 1;
      s = s ^ c ^ t;
      c = cn;
    end
    sum_o = s + c;
  end
endmodule

// File: rtl/xpb_reduce_accum.sv
// xpb_reduce_accum: drives digits to the external xpb tables and sums low word plus all
// table outputs, TERMS_PER_CYC per cycle, into a non-reduced SUM_W result.
module xpb_reduce_accum import xpb_pkg::*; #(
  parameter int WORD_W = XPB_WORD_W,
  parameter int IDX_W = XPB_IDX_W,
  parameter int NUM_DIGITS = 8,
  parameter int TERMS_PER_CYC = 2,
  parameter int LUT_LAT = 1,
  localparam int SUM_W = sum_w(WORD_W, NUM_DIGITS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            low_in,
  input  logic [NUM_DIGITS*IDX_W-1:0]  idx_in,
  output logic [NUM_DIGITS*IDX_W-1:0]  lut_idx,
  input  logic [NUM_DIGITS*WORD_W-1:0] lut_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [SUM_W-1:0]             sum_out
);
  localparam int T = TERMS_PER_CYC;
  localparam int G = (NUM_DIGITS + T - 1) / T;
  localparam int CW = $clog2(LUT_LAT + 1);
  localparam int GW = $clog2(G > 1 ? G : 2);
  localparam int PADW = G * T * WORD_W;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [GW-1:0] g_q, g_d;
  logic [SUM_W-1:0] acc_q, acc_d, acc_sum;
  logic [NUM_DIGITS*IDX_W-1:0] idx_q, idx_d;
  logic [PADW-1:0] padded;
  logic [T*WORD_W-1:0] terms;
  // Zero padding makes entries past NUM_DIGITS contribute nothing in the last group.
  assign padded = PADW'(lut_data);
  assign terms = padded[g_q*T*WORD_W +: T*WORD_W];
  xpb_term_adder #(.WORD_W(WORD_W), .T(T), .SUM_W(SUM_W)) u_add (
    .acc_i(acc_q), .terms_i(terms), .sum_o(acc_sum)
  );
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign sum_out = acc_q;
  assign lut_idx = idx_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    g_d = g_q;
    acc_d = acc_q;
    idx_d = idx_q;
    case (state_q)
      IDLE: if (in_valid) begin
        idx_d = idx_in;
        acc_d = SUM_W'(low_in);
        cnt_d = '0;
        state_d = LOOKUP;
      end
      LOOKUP: if (cnt_q == CW'(LUT_LAT - 1)) begin
        cnt_d = '0;
        g_d = '0;
        state_d = ACCUM;
      end else cnt_d = cnt_q + 1'b1;
      ACCUM: begin
        acc_d = acc_sum;
        g_d = g_q + 1'b1;
        if (g_q == GW'(G - 1)) begin
          g_d = '0;
          state_d = DONE;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      g_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      g_q <= g_d;
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end
endmodule

// File: tb/tb_xpb_reduce_accum.sv
// tb_xpb_reduce_accum: registered xpb table bank model, directed vectors and a random
// valid/ready stream checked against a big-integer sum of table entries.
module tb_xpb_reduce_accum;
  localparam int W = 1024;
  localparam int I = 5;
  localparam int N = 8;
  localparam int SW = W + $clog2(N + 1);
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [W-1:0] low_in = '0;
  logic [N*I-1:0] idx_in = '0, lut_idx;
  logic [N*W-1:0] lut_data = '0;
  logic [SW-1:0] sum_out;
  logic [W-1:0] tbl [N][32];
  logic [SW-1:0] exp_q [$];
  int checks = 0, failures = 0;
  typedef struct {
    logic [W-1:0] low;
    logic [N*I-1:0] idx;
    logic [SW-1:0] exp;
    int lat;
  } vec_t;
  vec_t vecs [4];

  xpb_reduce_accum dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .low_in(low_in), .idx_in(idx_in), .lut_idx(lut_idx), .lut_data(lut_data),
    .out_valid(out_valid), .out_ready(out_ready), .sum_out(sum_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    for (int k = 0; k < N; k++) lut_data[k*W +: W] <= tbl[k][lut_idx[k*I +: I]];

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int w = 0; w < W / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [SW-1:0] golden(input logic [W-1:0] low, input logic [N*I-1:0] idx);
    logic [SW-1:0] s;
    s = SW'(low);
    for (int k = 0; k < N; k++) s = s + SW'(tbl[k][idx[k*I +: I]]);
    return s;
  endfunction

  task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h..%h exp=%h..%h", name, got[SW-1:W-4], got[63:0], exp[SW-1:W-4], exp[63:0]);
    end
  endtask

  task automatic run_op(input logic [W-1:0] low, input logic [N*I-1:0] idx,
                        output logic [SW-1:0] res, output int lat);
    int t;
    @(negedge clk);
    low_in = low;
    idx_in = idx;
    in_valid = 1;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("accept_timeout", SW'(t < 50), 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = sum_out;
  endtask

  task automatic ack();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
    check("ack_out_valid", SW'(out_valid), 0);
    check("ack_in_ready", SW'(in_ready), 1);
  endtask

  initial begin
    logic [SW-1:0] res, held;
    logic [W-1:0] low;
    logic [N*I-1:0] idx;
    int lat;
    for (int k = 0; k < N; k++)
      for (int v = 0; v < 32; v++) tbl[k][v] = (v == 0) ? '0 : rand_word();
    repeat (3) @(negedge clk);
    check("rst_out_valid", SW'(out_valid), 0);
    check("rst_sum", sum_out, 0);
    check("rst_lut_idx", SW'(lut_idx), 0);
    rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", SW'(in_ready), 1);

    vecs[0] = '{W'(32'h1234), '0, SW'(32'h1234), 5};
    idx = '0;
    idx[I-1:0] = 5'd1;
    vecs[1] = '{'0, idx, SW'(tbl[0][1]), 5};
    idx = '0;
    idx[7*I +: I] = 5'd31;
    vecs[2] = '{'0, idx, SW'(tbl[7][31]), 5};
    vecs[3] = '{'1, {N{5'd31}}, golden('1, {N{5'd31}}), 5};
    for (int v = 0; v < 4; v++) begin
      run_op(vecs[v].low, vecs[v].idx, res, lat);
      check($sformatf("vec%0d_sum", v), res, vecs[v].exp);
      check($sformatf("vec%0d_lat", v), SW'(lat), SW'(vecs[v].lat));
      check($sformatf("vec%0d_lut_idx", v), SW'(lut_idx), SW'(vecs[v].idx));
      if (v == 3) check("no_truncation", SW'(|res[SW-1:W]), 1);
      ack();
    end

    low = rand_word();
    idx = N*I'($urandom);
    run_op(low, idx, res, lat);
    held = res;
    check("stall_sum", res, golden(low, idx));
    for (int c = 0; c < 10; c++) begin
      in_valid = 1;
      low_in = rand_word();
      idx_in = N*I'($urandom);
      @(negedge clk);
      check("stall_hold_sum", sum_out, held);
      check("stall_hold_valid", SW'(out_valid), 1);
      check("stall_in_ready", SW'(in_ready), 0);
    end
    in_valid = 0;
    ack();

    low = rand_word();
    idx = N*I'($urandom);
    @(negedge clk);
    low_in = low;
    idx_in = idx;
    in_valid = 1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    check("abort_out_valid", SW'(out_valid), 0);
    check("abort_sum", sum_out, 0);
    check("abort_lut_idx", SW'(lut_idx), 0);
    @(negedge clk);
    rst_n = 1;
    low = rand_word();
    idx = N*I'($urandom);
    run_op(low, idx, res, lat);
    check("post_abort_sum", res, golden(low, idx));
    check("post_abort_lat", SW'(lat), 5);
    ack();

    fork
      begin
        int t;
        for (int n = 0; n < 200; n++) begin
          low = rand_word();
          idx = N*I'($urandom);
          @(negedge clk);
          low_in = low;
          idx_in = idx;
          in_valid = 1;
          t = 0;
          while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
          end
          if (t >= 200) begin
            check("stream_accept_timeout", 0, 1);
            break;
          end
          exp_q.push_back(golden(low, idx));
          @(posedge clk);
          if ($urandom_range(3) == 0) begin
            @(negedge clk);
            in_valid = 0;
            repeat ($urandom_range(3)) @(negedge clk);
          end
        end
        @(negedge clk);
        in_valid = 0;
      end
      begin
        int got = 0, cyc = 0;
        while (got < 200 && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          out_ready = $urandom_range(1);
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("stream_unexpected", 0, 1);
            else check($sformatf("stream%0d", got), sum_out, exp_q.pop_front());
            got++;
          end
        end
        check("stream_count", SW'(got), 200);
        @(negedge clk);
        out_ready = 0;
      end
    join
    check("stream_leftover", SW'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
